ooo_mem_arbiter: RTL and testbench
==================================

Name: ooo_mem_arbiter

Overview:
- Sits between the L1 caches (icache, dcache) and the cacheline adaptor in front of physical memory, inside the mp4 top.
- Serialises 256-bit line fills (icache, dcache) and line write-backs (dcache) onto the single pmem port.
- Round-robin arbitration; one outstanding transaction at a time.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- LINE_WIDTH, 256, cacheline width in bits.
- OFFSET_BITS, 5, line-offset bits; forced to zero on pmem_address.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- ic_read  in  1  icache line-fill request; held high until ic_resp.
- ic_address  in  ADDR_WIDTH  icache line address.
- ic_rdata  out  LINE_WIDTH  fill data to icache.
- ic_resp  out  1  one-cycle completion pulse to icache.
- dc_read  in  1  dcache line-fill request; held until dc_resp.
- dc_write  in  1  dcache write-back request; held until dc_resp.
- dc_address  in  ADDR_WIDTH  dcache line address.
- dc_wdata  in  LINE_WIDTH  write-back data.
- dc_rdata  out  LINE_WIDTH  fill data to dcache.
- dc_resp  out  1  one-cycle completion pulse to dcache.
- pmem_read  out  1  line read to adaptor.
- pmem_write  out  1  line write to adaptor.
- pmem_address  out  ADDR_WIDTH  line-aligned address.
- pmem_wdata  out  LINE_WIDTH  write data.
- pmem_rdata  in  LINE_WIDTH  read data.
- pmem_resp  in  1  adaptor completion pulse.

Behaviour:
- States: IDLE, IC_READ, DC_READ, DC_WRITE, DONE.
- Reset (rst=0, asynchronous): state=IDLE, last_grant=ICACHE. All outputs 0 (pmem_read, pmem_write, pmem_address, pmem_wdata, ic/dc_resp, ic/dc_rdata). Any in-flight transaction is abandoned; no resp is issued for it.
- IDLE arbitration, sampled at the clock edge:
  - Only one client requesting: grant it.
  - Both requesting: grant the client not in last_grant (round-robin).
  - dc_write has priority over dc_read when both are high; dc_read is ignored that cycle.
  - On grant: next state IC_READ, DC_READ or DC_WRITE; last_grant updated.
- Busy states:
  - pmem_read or pmem_write driven from state (registered-state decode, no request-to-pmem combinational path).
  - pmem_address = granted client's address with the low OFFSET_BITS cleared, captured into a register at grant.
  - pmem_wdata = dc_wdata, captured at grant.
  - Latency: request seen at edge N, pmem command visible from cycle N+1.
- Completion:
  - When pmem_resp=1 in a busy state, the granted client's resp=1 in the same cycle; its rdata = pmem_rdata, combinational passthrough.
  - The non-granted resp stays 0.
  - Next state DONE.
- DONE: all pmem commands 0, no grant; one cycle only, so the client can drop its request. Then IDLE.
- Resp timing: ic_rdata/dc_rdata are only defined while the matching resp=1. They are 0 otherwise.
- Request deassert while granted is a protocol violation: the transaction completes anyway. A bench assertion flags it.
- pmem_resp in IDLE or DONE is ignored.
- Minimum turnaround: back-to-back transactions are separated by DONE plus IDLE, i.e. pmem command is low for 2 cycles.
- Starvation bound: with both clients requesting continuously, grants alternate strictly.

Decomposition:
- ooo_types gets:
  - enum arb_state_t {IDLE, IC_READ, DC_READ, DC_WRITE, DONE}.
  - enum arb_client_t {ICACHE, DCACHE}.
  - Constants LINE_WIDTH=256 and OFFSET_BITS=5, shared with the cache and adaptor.
- Single module plus one sub-module `arb_rr_picker`: combinational 2-way round-robin selector taking requests and last_grant, returning a grant and a valid flag.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, no requests → all outputs 0; after rst=1, pmem_read and pmem_write stay 0.
- Single icache fill at 0x0000_0064:
  - pmem_read=1 and pmem_address=0x0000_0060 from the next cycle.
  - Adaptor returns pmem_rdata={8{32'hDEADBEEF}} with pmem_resp → ic_resp=1 and ic_rdata equal to it that same cycle; dc_resp=0.
- Simultaneous ic_read @0x100 and dc_read @0x200 after reset (last_grant=ICACHE):
  - dcache is granted first.
  - After its resp, DONE, then IDLE, icache is granted.
  - The pmem_address sequence is 0x200 then 0x100.
- Write priority: dc_write and dc_read both high @0x40 with dc_wdata=256'h1 → pmem_write=1, pmem_read=0, pmem_wdata=256'h1; completion gives dc_resp=1.
- Reset mid-transaction: assert rst=0 two cycles into an IC_READ, while pmem_resp is still pending → pmem_read drops asynchronously. A later pmem_resp produces no ic_resp. After release, a fresh request is granted normally.
- Fairness: both clients requesting continuously for 6 transactions → the grant order alternates D, I, D, I, D, I.

Source files
------------

// File: rtl/ooo_types.sv
// Shared types and line geometry for the L1 caches, arbiter and adaptor.
package ooo_types;

  localparam int LINE_WIDTH  = 256;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [2:0] {
    IDLE,
    IC_READ,
    DC_READ,
    DC_WRITE,
    DONE
  } arb_state_t;

  typedef enum logic {
    ICACHE,
    DCACHE
  } arb_client_t;

endpackage

// File: rtl/arb_rr_picker.sv
// Two-way round-robin selector: the client that did not win last time
// wins a tie.
module arb_rr_picker
  import ooo_types::*;
(
  input  logic        req_ic,
  input  logic        req_dc,
  input  arb_client_t last_grant,
  output arb_client_t grant,
  output logic        valid
);

  always_comb begin
    grant = ICACHE;
    valid = req_ic | req_dc;
    unique case (1'b1)
      (req_ic && req_dc): begin
        if (last_grant == ICACHE) grant = DCACHE;
        else                      grant = ICACHE;
      end
      (req_dc && !req_ic): grant = DCACHE;
      default:             grant = ICACHE;
    endcase
  end

endmodule

// File: rtl/ooo_mem_arbiter.sv
// Serialises icache/dcache line fills and dcache write-backs onto the
// single pmem port, one transaction at a time.
module ooo_mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = ooo_types::LINE_WIDTH,
  parameter int OFFSET_BITS = ooo_types::OFFSET_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ic_read,
  input  logic [ADDR_WIDTH-1:0] ic_address,
  output logic [LINE_WIDTH-1:0] ic_rdata,
  output logic                  ic_resp,
  input  logic                  dc_read,
  input  logic                  dc_write,
  input  logic [ADDR_WIDTH-1:0] dc_address,
  input  logic [LINE_WIDTH-1:0] dc_wdata,
  output logic [LINE_WIDTH-1:0] dc_rdata,
  output logic                  dc_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  import ooo_types::*;

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  arb_state_t  state, state_nx;
  arb_client_t last_grant, last_nx, pick;
  logic        pick_vld;
  logic        busy;

  logic [ADDR_WIDTH-1:0] addr_q, addr_nx;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_nx;

  arb_rr_picker u_picker (
    .req_ic     (ic_read),
    .req_dc     (dc_read | dc_write),
    .last_grant (last_grant),
    .grant      (pick),
    .valid      (pick_vld)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= ICACHE;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state      <= state_nx;
      last_grant <= last_nx;
      addr_q     <= addr_nx;
      wdata_q    <= wdata_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    last_nx    = last_grant;
    addr_nx    = addr_q;
    wdata_nx   = wdata_q;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    ic_resp    = 1'b0;
    dc_resp    = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          last_nx = pick;
          if (pick == ICACHE) begin
            state_nx = IC_READ;
            addr_nx  = ic_address & LINE_MASK;
          end else begin
            // a pending write-back wins over a fill from the same cache
            if (dc_write) state_nx = DC_WRITE;
            else          state_nx = DC_READ;
            addr_nx  = dc_address & LINE_MASK;
            wdata_nx = dc_wdata;
          end
        end
      end
      IC_READ: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          ic_resp  = 1'b1;
          state_nx = DONE;
        end
      end
      DC_READ: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          dc_resp  = 1'b1;
          state_nx = DONE;
        end
      end
      DC_WRITE: begin
        pmem_write = 1'b1;
        if (pmem_resp) begin
          dc_resp  = 1'b1;
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy         = pmem_read | pmem_write;
  assign pmem_address = busy ? addr_q : '0;
  assign pmem_wdata   = (state == DC_WRITE) ? wdata_q : '0;
  assign ic_rdata     = ic_resp ? pmem_rdata : '0;
  assign dc_rdata     = dc_resp ? pmem_rdata : '0;

endmodule

// File: tb/tb_ooo_mem_arbiter.sv
// Self-checking bench for ooo_mem_arbiter: directed scenarios plus a
// randomized run against a round-robin reference model.
module tb_ooo_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ic_read = 1'b0;
  logic [AW-1:0] ic_address = '0;
  logic [LW-1:0] ic_rdata;
  logic          ic_resp;
  logic          dc_read = 1'b0;
  logic          dc_write = 1'b0;
  logic [AW-1:0] dc_address = '0;
  logic [LW-1:0] dc_wdata = '0;
  logic [LW-1:0] dc_rdata;
  logic          dc_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  int checks = 0;
  int errors = 0;
  int owner  = 0;

  always #5 clk = ~clk;

  ooo_mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .ic_read      (ic_read),
    .ic_address   (ic_address),
    .ic_rdata     (ic_rdata),
    .ic_resp      (ic_resp),
    .dc_read      (dc_read),
    .dc_write     (dc_write),
    .dc_address   (dc_address),
    .dc_wdata     (dc_wdata),
    .dc_rdata     (dc_rdata),
    .dc_resp      (dc_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  // dropping a request while it owns the pmem port is a protocol violation
  always @(negedge clk) begin
    if (rst && (pmem_read || pmem_write)) begin
      if ((owner == 1 && !ic_read) ||
          (owner == 2 && !(dc_read || dc_write))) begin
        errors++;
        $display("FAIL proto_deassert owner=%0d ic=%b dc=%b%b",
                 owner, ic_read, dc_read, dc_write);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cmd(input int budget, output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < budget) begin
      if (pmem_read || pmem_write) ok = 1'b1;
      else begin
        step();
        cyc++;
      end
    end
  endtask

  // 0 = icache, 1 = dcache; a tie goes to whoever was not served last
  function automatic int pick(bit ic, bit dc, int last);
    if (ic && dc) return (last == 0) ? 1 : 0;
    if (dc) return 1;
    return 0;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pmem_resp = 1'b1;
    pmem_rdata = {8{32'hA5A5_5A5A}};
    repeat (3) step();
    checks++;
    if ({pmem_read, pmem_write, ic_resp, dc_resp} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000",
               {pmem_read, pmem_write, ic_resp, dc_resp});
    end
    checks++;
    if (pmem_address !== '0) begin
      errors++;
      $display("FAIL reset_addr got %h want 0", pmem_address);
    end
    checks++;
    if (pmem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_wdata got %h want 0", pmem_wdata);
    end
    checks++;
    if ((ic_rdata | dc_rdata) !== '0) begin
      errors++;
      $display("FAIL reset_rdata ic %h dc %h want 0", ic_rdata, dc_rdata);
    end
    pmem_resp = 1'b0;
    rst = 1'b1;
    repeat (2) begin
      step();
      checks++;
      if ({pmem_read, pmem_write} !== 2'b00) begin
        errors++;
        $display("FAIL idle_cmd got %b want 00", {pmem_read, pmem_write});
      end
    end
  endtask

  task automatic test_icache_fill();
    logic [LW-1:0] d;
    d = {8{32'hDEADBEEF}};
    ic_address = 32'h0000_0064;
    ic_read = 1'b1;
    step();
    checks++;
    if ({pmem_read, pmem_write} !== 2'b10 || pmem_address !== 32'h60) begin
      errors++;
      $display("FAIL ic_cmd got rw=%b addr=%h want 10 addr=00000060",
               {pmem_read, pmem_write}, pmem_address);
    end
    pmem_rdata = d;
    pmem_resp = 1'b1;
    #1;
    checks++;
    if (ic_resp !== 1'b1 || ic_rdata !== d) begin
      errors++;
      $display("FAIL ic_resp got %b %h want 1 %h", ic_resp, ic_rdata, d);
    end
    checks++;
    if (dc_resp !== 1'b0) begin
      errors++;
      $display("FAIL ic_dc_quiet got %b want 0", dc_resp);
    end
    step();
    pmem_resp = 1'b0;
    ic_read = 1'b0;
    #1;
    checks++;
    if ({ic_resp, pmem_read} !== 2'b00) begin
      errors++;
      $display("FAIL ic_done got %b want 00", {ic_resp, pmem_read});
    end
    step();
  endtask

  task automatic test_simultaneous();
    logic [LW-1:0] d;
    do_reset();
    ic_address = 32'h100;
    dc_address = 32'h200;
    ic_read = 1'b1;
    dc_read = 1'b1;
    step();
    checks++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h200) begin
      errors++;
      $display("FAIL sim_first got rd=%b addr=%h want 1 00000200",
               pmem_read, pmem_address);
    end
    d = {8{$urandom}};
    pmem_rdata = d;
    pmem_resp = 1'b1;
    #1;
    checks++;
    if ({dc_resp, ic_resp} !== 2'b10 || dc_rdata !== d) begin
      errors++;
      $display("FAIL sim_dc_resp got %b %h want 10 %h",
               {dc_resp, ic_resp}, dc_rdata, d);
    end
    step();
    pmem_resp = 1'b0;
    dc_read = 1'b0;
    #1;
    checks++;
    if (pmem_read !== 1'b0) begin
      errors++;
      $display("FAIL sim_done got %b want 0", pmem_read);
    end
    step();
    checks++;
    if (pmem_read !== 1'b0) begin
      errors++;
      $display("FAIL sim_idle got %b want 0", pmem_read);
    end
    step();
    checks++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h100) begin
      errors++;
      $display("FAIL sim_second got rd=%b addr=%h want 1 00000100",
               pmem_read, pmem_address);
    end
    pmem_resp = 1'b1;
    #1;
    checks++;
    if ({dc_resp, ic_resp} !== 2'b01) begin
      errors++;
      $display("FAIL sim_ic_resp got %b want 01", {dc_resp, ic_resp});
    end
    step();
    pmem_resp = 1'b0;
    ic_read = 1'b0;
    step();
  endtask

  task automatic test_write_priority();
    dc_address = 32'h40;
    dc_wdata = 256'h1;
    dc_read = 1'b1;
    dc_write = 1'b1;
    step();
    checks++;
    if ({pmem_read, pmem_write} !== 2'b01 || pmem_wdata !== 256'h1 ||
        pmem_address !== 32'h40) begin
      errors++;
      $display("FAIL wr_cmd got rw=%b addr=%h wd=%h want 01 00000040 1",
               {pmem_read, pmem_write}, pmem_address, pmem_wdata);
    end
    pmem_resp = 1'b1;
    #1;
    checks++;
    if ({dc_resp, ic_resp} !== 2'b10) begin
      errors++;
      $display("FAIL wr_resp got %b want 10", {dc_resp, ic_resp});
    end
    step();
    pmem_resp = 1'b0;
    dc_read = 1'b0;
    dc_write = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    ic_address = 32'h0000_0080;
    ic_read = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || pmem_address !== '0) begin
      errors++;
      $display("FAIL mid_rst_cmd got rd=%b addr=%h want 0 0",
               pmem_read, pmem_address);
    end
    pmem_resp = 1'b1;
    #1;
    checks++;
    if (ic_resp !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_resp got %b want 0", ic_resp);
    end
    step();
    pmem_resp = 1'b0;
    rst = 1'b1;
    step();
    checks++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h80) begin
      errors++;
      $display("FAIL mid_rst_regrant got rd=%b addr=%h want 1 00000080",
               pmem_read, pmem_address);
    end
    pmem_resp = 1'b1;
    #1;
    checks++;
    if (ic_resp !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst_done got %b want 1", ic_resp);
    end
    step();
    pmem_resp = 1'b0;
    ic_read = 1'b0;
    step();
  endtask

  task automatic test_fairness();
    int last;
    int exp;
    int cyc;
    bit ok;
    do_reset();
    last = 0;
    ic_address = 32'h1000;
    dc_address = 32'h2000;
    ic_read = 1'b1;
    dc_read = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp = pick(1'b1, 1'b1, last);
      wait_cmd(8, ok, cyc);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL fair_timeout round %0d", i);
        break;
      end
      if (pmem_address !== (exp == 1 ? 32'h2000 : 32'h1000)) begin
        errors++;
        $display("FAIL fair_order round %0d got %h want client %0d",
                 i, pmem_address, exp);
      end
      if (i > 0) begin
        checks++;
        if (cyc != 2) begin
          errors++;
          $display("FAIL fair_gap round %0d got %0d want 2", i, cyc);
        end
      end
      pmem_resp = 1'b1;
      #1;
      checks++;
      if ({dc_resp, ic_resp} !== (exp == 1 ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL fair_resp round %0d got %b want client %0d",
                 i, {dc_resp, ic_resp}, exp);
      end
      step();
      pmem_resp = 1'b0;
      last = exp;
    end
    ic_read = 1'b0;
    dc_read = 1'b0;
    step();
  endtask

  task automatic test_random();
    int last;
    int exp;
    int cyc;
    int mode;
    bit ok;
    bit exp_wr;
    logic [AW-1:0] exp_addr;
    logic [LW-1:0] d;
    do_reset();
    last = 0;
    for (int i = 0; i < 24; i++) begin
      if (!ic_read && $urandom_range(0, 1) == 1) begin
        ic_address = $urandom;
        ic_read = 1'b1;
      end
      if (!(dc_read || dc_write) && $urandom_range(0, 1) == 1) begin
        dc_address = $urandom;
        mode = $urandom_range(0, 2);
        dc_read = (mode != 1);
        dc_write = (mode != 0);
        for (int w = 0; w < 8; w++) dc_wdata[w*32 +: 32] = $urandom;
      end
      if (!ic_read && !dc_read && !dc_write) begin
        ic_address = $urandom;
        ic_read = 1'b1;
      end
      exp = pick(ic_read, dc_read | dc_write, last);
      exp_wr = (exp == 1) && dc_write;
      exp_addr = (exp == 1 ? dc_address : ic_address) & ~32'h1f;
      owner = exp + 1;
      wait_cmd(6, ok, cyc);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rnd_timeout iter %0d", i);
        owner = 0;
        break;
      end
      if ({pmem_read, pmem_write} !== {!exp_wr, exp_wr} ||
          pmem_address !== exp_addr) begin
        errors++;
        $display("FAIL rnd_cmd iter %0d got rw=%b addr=%h want wr=%b addr=%h",
                 i, {pmem_read, pmem_write}, pmem_address, exp_wr, exp_addr);
      end
      if (exp_wr) begin
        checks++;
        if (pmem_wdata !== dc_wdata) begin
          errors++;
          $display("FAIL rnd_wdata iter %0d got %h want %h",
                   i, pmem_wdata, dc_wdata);
        end
      end
      repeat ($urandom_range(0, 3)) step();
      for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
      pmem_rdata = d;
      pmem_resp = 1'b1;
      #1;
      checks++;
      if (exp == 1) begin
        if ({dc_resp, ic_resp} !== 2'b10 || dc_rdata !== d ||
            ic_rdata !== '0) begin
          errors++;
          $display("FAIL rnd_resp iter %0d got %b dc %h want 10 %h",
                   i, {dc_resp, ic_resp}, dc_rdata, d);
        end
      end else begin
        if ({dc_resp, ic_resp} !== 2'b01 || ic_rdata !== d ||
            dc_rdata !== '0) begin
          errors++;
          $display("FAIL rnd_resp iter %0d got %b ic %h want 01 %h",
                   i, {dc_resp, ic_resp}, ic_rdata, d);
        end
      end
      step();
      pmem_resp = ($urandom_range(0, 1) == 1);
      owner = 0;
      if (exp == 1) begin
        dc_read = 1'b0;
        dc_write = 1'b0;
      end else begin
        ic_read = 1'b0;
      end
      #1;
      checks++;
      if ({ic_resp, dc_resp, pmem_read, pmem_write} !== 4'b0) begin
        errors++;
        $display("FAIL rnd_done iter %0d got %b want 0000",
                 i, {ic_resp, dc_resp, pmem_read, pmem_write});
      end
      if (pmem_resp) begin
        step();
        checks++;
        if ({ic_resp, dc_resp} !== 2'b00) begin
          errors++;
          $display("FAIL rnd_idle_resp iter %0d got %b want 00",
                   i, {ic_resp, dc_resp});
        end
        pmem_resp = 1'b0;
      end
      last = exp;
    end
    ic_read = 1'b0;
    dc_read = 1'b0;
    dc_write = 1'b0;
    pmem_resp = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_icache_fill();
    test_simultaneous();
    test_write_priority();
    test_reset_mid();
    test_fairness();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
